simon_host_serializer: RTL

//  Host-side driver for the bit-serial SIMON core. Takes a parallel plaintext
//  (and an optional key), shifts it LSB-first into the core over data_in/data_rdy,
//  and gathers the serial cipher_out stream into a parallel ciphertext word.

---
 rtl/simon_host_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/simon_host_serializer.sv
// simon_host_serializer: host-side driver for the bit-serial SIMON core.
//   Captures a parallel plaintext (and optionally a key) on start, shifts the
//   key and then the plaintext LSB-first into the core, waits for the core to
//   raise valid, and assembles the serial ciphertext into ct_out.
// Ports:
//   clk, reset      system clock (rising edge), asynchronous active-low reset
//   start, load_key encryption request (IDLE only); 1 = send key phase first
//   pt_in, key_in   plaintext / key captured when start is accepted
//   busy            high from accept until the done/err cycle
//   done, err       one-cycle pulses: ct_out updated / RUN timed out
//   ct_out          last ciphertext, held until the next done
//   data_in         registered serial bit to the core
//   data_rdy        registered core phase: 00 idle, 10 key, 01 plaintext, 11 run
//   cipher_out      serial ciphertext bit from the core, qualified by valid
module simon_host_serializer #(
   parameter int BLOCK_BITS = 128,
   parameter int KEY_BITS   = 128,
   parameter int MAX_WAIT   = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load_key,
   input  logic [BLOCK_BITS-1:0] pt_in,
   input  logic [KEY_BITS-1:0]   key_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BLOCK_BITS-1:0] ct_out,
   output logic                  data_in,
   output logic [1:0]            data_rdy,
   input  logic                  cipher_out,
   input  logic                  valid
);
   localparam int MAXB = BLOCK_BITS > KEY_BITS ? BLOCK_BITS : KEY_BITS;
   localparam int CW   = $clog2(MAXB) + 1;
   localparam int WW   = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BITS - 1);
   localparam logic [CW-1:0] PT_LAST  = CW'(BLOCK_BITS - 1);
   localparam logic [CW-1:0] CT_LAST  = CW'(BLOCK_BITS - 2);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, RUN, CAPTURE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WW-1:0]         wait_q, wait_d, wait_inc;
   logic [KEY_BITS-1:0]   key_sh_q, key_sh_d;
   logic [BLOCK_BITS-1:0] pt_sh_q, pt_sh_d;
   logic [BLOCK_BITS-2:0] ct_sh_q, ct_sh_d;
   logic [BLOCK_BITS-1:0] ct_out_q, ct_out_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                  data_in_q, data_in_d;
   logic [1:0]            data_rdy_q, data_rdy_d;
   logic                  accept, key_end, pt_end, timeout, ct_end;

   // A start landing on the done/err cycle is dropped so the pulse is seen first.
   assign accept   = state_q == IDLE && start && !done_q && !err_q;
   assign key_end  = cnt_q == KEY_LAST;
   assign pt_end   = cnt_q == PT_LAST;
   assign wait_inc = wait_q == WAIT_MAX ? wait_q : wait_q + 1'b1;
   assign timeout  = !valid && wait_inc == WAIT_MAX;
   assign ct_end   = valid && cnt_q == CT_LAST;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wait_q     <= '0;
         key_sh_q   <= '0;
         pt_sh_q    <= '0;
         ct_sh_q    <= '0;
         ct_out_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         data_in_q  <= 1'b0;
         data_rdy_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         key_sh_q   <= key_sh_d;
         pt_sh_q    <= pt_sh_d;
         ct_sh_q    <= ct_sh_d;
         ct_out_q   <= ct_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         data_in_q  <= data_in_d;
         data_rdy_q <= data_rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = load_key ? LOAD_KEY : LOAD_PT;
         LOAD_KEY: if (key_end) state_d = LOAD_PT;
         LOAD_PT:  if (pt_end) state_d = RUN;
         RUN:      if (valid) state_d = CAPTURE; else if (timeout) state_d = IDLE;
         CAPTURE:  if (ct_end) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // data_in/data_rdy are computed one cycle ahead from state_d so the core sees
   // flop outputs. Shadows shift right; the bit sent on accept is taken straight
   // from the input, so the shadow is stored already shifted by one.
   always_comb begin
      cnt_d      = state_q == IDLE || state_d != state_q ? '0 :
                   state_q == CAPTURE && !valid ? cnt_q : cnt_q + 1'b1;
      wait_d     = state_q == RUN ? wait_inc : '0;
      key_sh_d   = accept ? key_in >> 1 : state_q == LOAD_KEY ? key_sh_q >> 1 : key_sh_q;
      pt_sh_d    = accept ? (load_key ? pt_in : pt_in >> 1) :
                   state_q == LOAD_PT || (state_q == LOAD_KEY && key_end) ? pt_sh_q >> 1 : pt_sh_q;
      data_in_d  = accept ? (load_key ? key_in[0] : pt_in[0]) :
                   state_d == LOAD_KEY ? key_sh_q[0] :
                   state_d == LOAD_PT ? pt_sh_q[0] : 1'b0;
      data_rdy_d = state_d == LOAD_KEY ? 2'b10 :
                   state_d == LOAD_PT ? 2'b01 :
                   state_d == RUN || state_d == CAPTURE ? 2'b11 : 2'b00;
      ct_sh_d    = (state_q == RUN || state_q == CAPTURE) && valid ?
                   {cipher_out, ct_sh_q[BLOCK_BITS-2:1]} : ct_sh_q;
      done_d     = state_q == CAPTURE && ct_end;
      err_d      = state_q == RUN && timeout;
      ct_out_d   = done_d ? {cipher_out, ct_sh_q} : ct_out_q;
      busy_d     = state_d != IDLE;
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ct_out   = ct_out_q;
   assign data_in  = data_in_q;
   assign data_rdy = data_rdy_q;
endmodule
